// File: rtl/dst_stream_out.sv
// Output stream packer: reads len+1 buffer words and streams them out through a 2-entry skid FIFO.
// Optional DST_RELU_EN clamps negative words to zero on FIFO push.
module dst_stream_out #(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          mem_re,
    output logic [AW-1:0] mem_a,
    input  logic [DW-1:0] mem_d,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] len_q, rd_a_q;
    logic          out_q, tag_q, done_q;
    logic [DW:0]   ent_q [2];
    logic          wp_q, rp_q;
    logic [1:0]    cnt_q;

    logic [DW-1:0] din;
    logic [DW:0]   head;
    logic [2:0]    occ;
    logic          pop, push, fpop, issue, last_issue;

`ifdef DST_RELU_EN
    assign din = mem_d[DW-1] ? '0 : mem_d;
`else
    assign din = mem_d;
`endif

    // Returning read data falls through to the head when the FIFO is empty
    always_comb begin
        head       = (cnt_q != 2'd0) ? ent_q[rp_q] : {tag_q, din};
        pop        = m_valid & m_ready;
        push       = out_q & ~(pop & (cnt_q == 2'd0));
        fpop       = pop & (cnt_q != 2'd0);
        occ        = {1'b0, cnt_q} + {2'b00, out_q} - {2'b00, pop};
        issue      = (state_q == RUN) && (occ < 3'd2);
        last_issue = issue && (rd_a_q == len_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_issue) state_d = DRAIN;
            DRAIN:   if (pop && head[DW]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        done    = done_q;
        mem_re  = issue;
        mem_a   = issue ? rd_a_q : '0;
        m_valid = (cnt_q != 2'd0) | out_q;
        m_data  = m_valid ? head[DW-1:0] : '0;
        m_last  = m_valid & head[DW];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            rd_a_q   <= '0;
            out_q    <= 1'b0;
            tag_q    <= 1'b0;
            done_q   <= 1'b0;
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (state_q == IDLE && start) begin
                len_q  <= len;
                rd_a_q <= '0;
            end else if (issue && !last_issue) begin
                rd_a_q <= rd_a_q + AW'(1);
            end
            out_q  <= issue;
            tag_q  <= last_issue;
            done_q <= (state_q == DRAIN) && pop && head[DW];
            if (push) begin
                ent_q[wp_q] <= {tag_q, din};
                wp_q        <= ~wp_q;
            end
            if (fpop) rp_q <= ~rp_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, fpop};
        end
    end

endmodule

// File: tb/tb_dst_stream_out.sv
// Self-checking bench for dst_stream_out against a word-list reference model.
// Covers timing, backpressure, ignored restarts, reset mid-transfer and ReLU.
module tb_dst_stream_out;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] len = '0;
    logic          busy, done, mem_re, m_valid, m_last;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d = '0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;

    logic [DW-1:0] bufm [0:(1<<AW)-1];
    int tests = 0;
    int fails = 0;

    dst_stream_out #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .mem_re(mem_re), .mem_a(mem_a),
        .mem_d(mem_d), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_re) mem_d <= bufm[mem_a];

    function automatic logic [DW-1:0] xw(input logic [DW-1:0] w);
`ifdef DST_RELU_EN
        if ($signed(w) < 0) return '0;
        return w;
`else
        return w;
`endif
    endfunction

    task automatic chk_zero(input string nm);
        tests++;
        if ({busy, done, mem_re, m_valid, m_last} !== 5'b0 ||
            mem_a !== '0 || m_data !== '0) begin
            fails++;
            $display("FAIL %s: ctl=%b mem_a=%0d m_data=%h, required all 0",
                     nm, {busy, done, mem_re, m_valid, m_last}, mem_a, m_data);
        end
    endtask

    // mode 0: ready high, 1: pattern 1,0,0,1, 2: random
    task automatic run_xfer(input int l, input int mode, input int restart_k,
                            input int rst_after, input string nm);
        int k, beats, issued, ndone, done_k, limit;
        logic pstall;
        logic [DW-1:0] pdata;
        logic plast;
        @(negedge clk);
        start = 1'b1;
        len = AW'(l);
        m_ready = (mode == 0);
        k = 0; beats = 0; issued = 0; ndone = 0; done_k = -1;
        pstall = 1'b0; pdata = '0; plast = 1'b0;
        limit = 8 * (l + 1) + 20;
        forever begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (k == restart_k) begin
                start = 1'b1;
                len = AW'(3);
            end
            if (rst_after >= 0 && beats == rst_after + 1) begin
                rst = 1'b1;
                #1;
                chk_zero({nm, "_rst_outputs"});
                @(negedge clk);
                rst = 1'b0;
                m_ready = 1'b0;
                return;
            end
            if (mode == 0) m_ready = 1'b1;
            else if (mode == 1) m_ready = (k % 4 == 0) || (k % 4 == 3);
            else m_ready = 1'($urandom_range(0, 1));
            #1;
            if (k == 1) begin
                tests++;
                if (busy !== 1'b1 || mem_re !== 1'b1 || mem_a !== '0) begin
                    fails++;
                    $display("FAIL %s_first_cycle: busy=%b mem_re=%b mem_a=%0d, required 1 1 0",
                             nm, busy, mem_re, mem_a);
                end
            end
            if (done_k < 0 && !done) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL %s_busy: busy=%b at cycle %0d, required 1", nm, busy, k);
                end
            end
            if (pstall) begin
                tests++;
                if (m_valid !== 1'b1 || m_data !== pdata || m_last !== plast) begin
                    fails++;
                    $display("FAIL %s_stall_stable: v=%b d=%h l=%b, required 1 %h %b",
                             nm, m_valid, m_data, m_last, pdata, plast);
                end
            end
            if (mem_re === 1'b1) begin
                tests++;
                if (mem_a !== AW'(issued) || issued > l) begin
                    fails++;
                    $display("FAIL %s_read_addr: mem_a=%0d, required %0d (max %0d)",
                             nm, mem_a, issued, l);
                end
                issued++;
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                tests++;
                if (beats > l) begin
                    fails++;
                    $display("FAIL %s_extra_beat: beat %0d data=%h, required none", nm, beats, m_data);
                end else if (m_data !== xw(bufm[beats]) || m_last !== (beats == l)) begin
                    fails++;
                    $display("FAIL %s_beat: beat %0d data=%h last=%b, required %h %b",
                             nm, beats, m_data, m_last, xw(bufm[beats]), beats == l);
                end
                if (mode == 0) begin
                    tests++;
                    if (k != 2 + beats) begin
                        fails++;
                        $display("FAIL %s_beat_cycle: beat %0d at cycle %0d, required %0d",
                                 nm, beats, k, 2 + beats);
                    end
                end
                beats++;
            end
            tests++;
            if (issued - beats > 2) begin
                fails++;
                $display("FAIL %s_occupancy: %0d words buffered, required <= 2", nm, issued - beats);
            end
            if (done === 1'b1) begin
                ndone++;
                if (done_k < 0) done_k = k;
                tests++;
                if (busy !== 1'b0 || (mode == 0 && k != 3 + l)) begin
                    fails++;
                    $display("FAIL %s_done: done at cycle %0d busy=%b, required cycle %0d busy 0",
                             nm, k, busy, 3 + l);
                end
            end
            pstall = m_valid & ~m_ready;
            pdata = m_data;
            plast = m_last;
            if (done_k >= 0 && k >= done_k + 3) break;
            if (k >= limit) begin
                tests++;
                fails++;
                $display("FAIL %s_timeout: no done after %0d cycles, required done", nm, k);
                break;
            end
        end
        tests++;
        if (beats != l + 1 || ndone != 1) begin
            fails++;
            $display("FAIL %s_totals: beats=%0d dones=%0d, required %0d and 1",
                     nm, beats, ndone, l + 1);
        end
        m_ready = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) bufm[i] = $urandom;
    endtask

    task automatic test_reset;
        #1;
        chk_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("idle_after_reset");
    endtask

    task automatic test_len7;
        for (int i = 0; i < 8; i++) bufm[i] = DW'(i + 100);
        run_xfer(7, 0, -1, -1, "len7");
    endtask

    task automatic test_len0;
        bufm[0] = 32'hDEADBEEF;
        run_xfer(0, 0, -1, -1, "len0");
    endtask

    task automatic test_backpressure;
        fill_rand(16);
        run_xfer(15, 1, -1, -1, "bp_pattern");
        fill_rand(40);
        run_xfer(39, 2, -1, -1, "bp_random");
    endtask

    task automatic test_restart_ignored;
        fill_rand(10);
        run_xfer(9, 2, 4, -1, "restart");
    endtask

    task automatic test_reset_mid;
        fill_rand(10);
        run_xfer(9, 0, -1, 4, "rst_mid");
        for (int i = 0; i < 3; i++) bufm[i] = $urandom | 32'h1000;
        run_xfer(2, 0, -1, -1, "after_rst");
    endtask

    task automatic test_relu_data;
        bufm[0] = 32'hFFFFFFFB;
        bufm[1] = 32'd7;
        bufm[2] = 32'h80000000;
        bufm[3] = 32'd3;
        run_xfer(3, 2, -1, -1, "relu");
    endtask

    task automatic test_max_len;
        fill_rand(1 << AW);
        run_xfer((1 << AW) - 1, 2, -1, -1, "max_len");
    endtask

    initial begin
        test_reset();
        test_len7();
        test_len0();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid();
        test_relu_data();
        test_max_len();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
